// File: rtl/dpram_arb_pkg.sv
// Shared types and defaults for the dual-port RAM port arbiter.
// Requester indices are sized for the largest supported requester count.
package dpram_arb_pkg;

   localparam int ADDR_W_DEF  = 4;
   localparam int DATA_W_DEF  = 4;
   localparam int NUM_REQ_DEF = 3;
   localparam int NUM_REQ_MAX = 8;
   localparam int IDX_W       = $clog2(NUM_REQ_MAX);

   typedef logic [IDX_W-1:0] req_idx_t;

   typedef enum logic {
      PORT1 = 1'b0,
      PORT2 = 1'b1
   } port_e;

   // Successor of idx in round-robin order over n requesters.
   function automatic req_idx_t next_idx(input req_idx_t idx, input int n);
      if (int'(idx) >= n - 1)
         return '0;
      return req_idx_t'(int'(idx) + 1);
   endfunction

endpackage

// File: rtl/dpram_rr_pick.sv
// Rotating find-first: returns the first set bit of mask, scanning upward
// from start with wrap-around.
module dpram_rr_pick
   import dpram_arb_pkg::*;
#(
   parameter int N = NUM_REQ_DEF
) (
   input  logic [N-1:0] mask,
   input  req_idx_t     start,
   output logic         found,
   output req_idx_t     idx
);

   always_comb begin
      found = 1'b0;
      idx   = '0;
      // Scan from farthest to nearest so the nearest hit is the one kept.
      for (int k = N - 1; k >= 0; k--) begin
         if (mask[(int'(start) + k) % N]) begin
            found = 1'b1;
            idx   = req_idx_t'((int'(start) + k) % N);
         end
      end
   end

endmodule

// File: rtl/dpram_port_arbiter.sv
// Round-robin arbiter sharing both ports of a dual-port RAM between NUM_REQ
// requesters, with same-address hazard blocking and a one-cycle read return.
module dpram_port_arbiter
   import dpram_arb_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ-1:0]        req_we,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [NUM_REQ*DATA_W-1:0] rsp_rdata,
   output logic                      we1,
   output logic                      we2,
   output logic [ADDR_W-1:0]         addr1,
   output logic [ADDR_W-1:0]         addr2,
   output logic [DATA_W-1:0]         data_in1,
   output logic [DATA_W-1:0]         data_in2,
   input  logic [DATA_W-1:0]         data_out1,
   input  logic [DATA_W-1:0]         data_out2
);

   req_idx_t             rr_ptr_reg, rr_ptr_next;
   logic                 g1_found, g2_found;
   req_idx_t             g1_idx, g2_idx, g2_start;
   logic [NUM_REQ-1:0]   g2_mask;
   logic                 g1_we, g2_we;
   logic [ADDR_W-1:0]    g1_addr, g2_addr;
   logic [DATA_W-1:0]    g1_wdata, g2_wdata;
   logic                 hazard, grant1, grant2;
   logic                 p1_valid_reg, p2_valid_reg;
   req_idx_t             p1_idx_reg, p2_idx_reg;

   dpram_rr_pick #(.N(NUM_REQ)) u_pick1 (
      .mask  (req_valid),
      .start (rr_ptr_reg),
      .found (g1_found),
      .idx   (g1_idx)
   );

   always_comb begin
      g2_mask  = req_valid;
      g2_start = next_idx(g1_idx, NUM_REQ);
      for (int i = 0; i < NUM_REQ; i++) begin
         if (int'(g1_idx) == i)
            g2_mask[i] = 1'b0;
      end
   end

   dpram_rr_pick #(.N(NUM_REQ)) u_pick2 (
      .mask  (g2_mask),
      .start (g2_start),
      .found (g2_found),
      .idx   (g2_idx)
   );

   always_comb begin
      g1_we    = 1'b0;
      g1_addr  = '0;
      g1_wdata = '0;
      g2_we    = 1'b0;
      g2_addr  = '0;
      g2_wdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (int'(g1_idx) == i) begin
            g1_we    = req_we[i];
            g1_addr  = req_addr[i*ADDR_W +: ADDR_W];
            g1_wdata = req_wdata[i*DATA_W +: DATA_W];
         end
         if (int'(g2_idx) == i) begin
            g2_we    = req_we[i];
            g2_addr  = req_addr[i*ADDR_W +: ADDR_W];
            g2_wdata = req_wdata[i*DATA_W +: DATA_W];
         end
      end

      // Any write sharing an address with the other port holds off the second grant.
      hazard = g2_found && (g2_addr == g1_addr) && (g1_we || g2_we);
      grant1 = g1_found && rst;
      grant2 = g2_found && !hazard && rst;

      req_ready = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant1 && int'(g1_idx) == i)
            req_ready[i] = 1'b1;
         if (grant2 && int'(g2_idx) == i)
            req_ready[i] = 1'b1;
      end

      we1      = grant1 && g1_we;
      addr1    = grant1 ? g1_addr  : '0;
      data_in1 = grant1 ? g1_wdata : '0;
      we2      = grant2 && g2_we;
      addr2    = grant2 ? g2_addr  : '0;
      data_in2 = grant2 ? g2_wdata : '0;

      if (grant2)
         rr_ptr_next = next_idx(g2_idx, NUM_REQ);
      else if (grant1)
         rr_ptr_next = next_idx(g1_idx, NUM_REQ);
      else
         rr_ptr_next = rr_ptr_reg;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_ptr_reg   <= '0;
         p1_valid_reg <= 1'b0;
         p2_valid_reg <= 1'b0;
         p1_idx_reg   <= '0;
         p2_idx_reg   <= '0;
      end else begin
         rr_ptr_reg   <= rr_ptr_next;
         p1_valid_reg <= grant1 && !g1_we;
         p2_valid_reg <= grant2 && !g2_we;
         p1_idx_reg   <= g1_idx;
         p2_idx_reg   <= g2_idx;
      end
   end

   // The RAM registers its read data, so it lines up with the recorded grant.
   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
         logic  hit1, hit2;
         port_e src;
         assign hit1 = p1_valid_reg && (p1_idx_reg == req_idx_t'(gi));
         assign hit2 = p2_valid_reg && (p2_idx_reg == req_idx_t'(gi));
         assign src  = hit1 ? PORT1 : PORT2;
         assign rsp_valid[gi] = hit1 || hit2;
         assign rsp_rdata[gi*DATA_W +: DATA_W] =
            !(hit1 || hit2) ? '0 : ((src == PORT1) ? data_out1 : data_out2);
      end
   endgenerate

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Randomized and directed bench for dpram_port_arbiter with a behavioural
// RAM and a rule-level reference model of grants, pointer and responses.
module tb_dpram_port_arbiter;
   import dpram_arb_pkg::*;

   localparam int N  = 3;
   localparam int AW = 4;
   localparam int DW = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid, req_we, req_ready, rsp_valid;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata, rsp_rdata;
   logic            we1, we2;
   logic [AW-1:0]   addr1, addr2;
   logic [DW-1:0]   data_in1, data_in2, data_out1, data_out2;

   logic [AW-1:0]   r_addr  [N];
   logic [DW-1:0]   r_wdata [N];
   logic [DW-1:0]   ram     [16];

   int              m_ptr;
   logic [DW-1:0]   m_mem   [16];
   logic [N-1:0]    m_gnt;
   logic [N-1:0]    exp_rsp_v;
   logic [DW-1:0]   exp_rsp_d [N];
   logic [N-1:0]    obs_ready, obs_rsp_v;
   logic [DW-1:0]   obs_rsp_d [N];
   logic [2:0]      pair_pat [3] = '{3'b011, 3'b101, 3'b110};

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always #5 clk = ~clk;

   dpram_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .we1       (we1),
      .we2       (we2),
      .addr1     (addr1),
      .addr2     (addr2),
      .data_in1  (data_in1),
      .data_in2  (data_in2),
      .data_out1 (data_out1),
      .data_out2 (data_out2)
   );

   always_comb begin
      req_addr  = '0;
      req_wdata = '0;
      for (int i = 0; i < N; i++) begin
         req_addr[i*AW +: AW]  = r_addr[i];
         req_wdata[i*DW +: DW] = r_wdata[i];
      end
   end

   // 16x4 dual-port RAM with registered read on both ports.
   always @(posedge clk) begin
      if (we1) ram[addr1] <= data_in1;
      if (we2) ram[addr2] <= data_in2;
      data_out1 <= ram[addr1];
      data_out2 <= ram[addr2];
   end

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic set_req(input int i, input bit we, input int a, input int d);
      req_valid[i] = 1'b1;
      req_we[i]    = we;
      r_addr[i]    = AW'(a);
      r_wdata[i]   = DW'(d);
   endtask

   // One clock cycle: called just after a rising edge with inputs applied.
   task automatic step();
      int            g1, g2, last;
      logic [N-1:0]  e_ready, new_v;
      logic          e_we1, e_we2;
      logic [AW-1:0] e_a1, e_a2;
      logic [DW-1:0] e_d1, e_d2;
      logic [DW-1:0] new_d [N];
      @(negedge clk);
      cyc++;
      g1 = -1;
      g2 = -1;
      for (int k = 0; k < N; k++) begin
         int j;
         j = (m_ptr + k) % N;
         if (req_valid[j]) begin
            if (g1 < 0) g1 = j;
            else if (g2 < 0) g2 = j;
         end
      end
      if (g2 >= 0 && r_addr[g2] == r_addr[g1] && (req_we[g1] || req_we[g2]))
         g2 = -1;
      e_ready = '0; e_we1 = 0; e_we2 = 0; e_a1 = 0; e_a2 = 0; e_d1 = 0; e_d2 = 0;
      if (g1 >= 0) begin
         e_ready[g1] = 1'b1; e_we1 = req_we[g1]; e_a1 = r_addr[g1]; e_d1 = r_wdata[g1];
      end
      if (g2 >= 0) begin
         e_ready[g2] = 1'b1; e_we2 = req_we[g2]; e_a2 = r_addr[g2]; e_d2 = r_wdata[g2];
      end
      obs_ready = req_ready;
      obs_rsp_v = rsp_valid;
      for (int i = 0; i < N; i++) obs_rsp_d[i] = rsp_rdata[i*DW +: DW];
      $display("cyc %0d ready=%b we=%b%b addr1=%0d addr2=%0d rsp_valid=%b",
               cyc, req_ready, we1, we2, addr1, addr2, rsp_valid);
      check_value("ready", req_ready, e_ready);
      check_value("we1", we1, e_we1);
      check_value("we2", we2, e_we2);
      check_value("addr1", addr1, e_a1);
      check_value("addr2", addr2, e_a2);
      check_value("data_in1", data_in1, e_d1);
      check_value("data_in2", data_in2, e_d2);
      check_value("rsp_valid", rsp_valid, exp_rsp_v);
      for (int i = 0; i < N; i++)
         if (exp_rsp_v[i]) check_value($sformatf("rsp_rdata%0d", i), obs_rsp_d[i], exp_rsp_d[i]);
      new_v = '0;
      for (int i = 0; i < N; i++) begin
         new_d[i] = '0;
         if (e_ready[i] && !req_we[i]) begin
            new_v[i] = 1'b1;
            new_d[i] = m_mem[r_addr[i]];
         end
      end
      for (int i = 0; i < N; i++)
         if (e_ready[i] && req_we[i]) m_mem[r_addr[i]] = r_wdata[i];
      last = (g2 >= 0) ? g2 : g1;
      if (last >= 0) m_ptr = (last + 1) % N;
      m_gnt = e_ready;
      @(posedge clk);
      exp_rsp_v = new_v;
      for (int i = 0; i < N; i++) exp_rsp_d[i] = new_d[i];
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      #1;
      check_value("rst_ready", req_ready, 0);
      check_value("rst_we", {we1, we2}, 0);
      check_value("rst_addr1", addr1, 0);
      check_value("rst_rsp_valid", rsp_valid, 0);
      m_ptr     = 0;
      exp_rsp_v = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   // Grant the requester just before p alone so the pointer lands on p.
   task automatic set_ptr(input int p);
      req_valid = '0;
      set_req((p + N - 1) % N, 1'b0, 15, 0);
      step();
      req_valid = '0;
      check_value("set_ptr", m_ptr, p);
   endtask

   initial begin
      rst       = 1'b0;
      req_valid = '0;
      req_we    = '0;
      exp_rsp_v = '0;
      m_ptr     = 0;
      m_gnt     = '0;
      for (int i = 0; i < N; i++) begin
         r_addr[i] = '0; r_wdata[i] = '0; exp_rsp_d[i] = '0;
      end
      for (int i = 0; i < 16; i++) begin
         ram[i] = '0; m_mem[i] = '0;
      end

      // Reset with every requester asking, then the fixed read rotation.
      for (int i = 0; i < N; i++) set_req(i, 1'b0, i * 4, 0);
      do_reset();
      for (int c = 0; c < 6; c++) begin
         step();
         check_value("rr_pair", obs_ready, pair_pat[c % 3]);
         for (int i = 0; i < N; i++)
            if (m_gnt[i]) set_req(i, 1'b0, i * 4 + int'($urandom_range(0, 3)), 0);
      end

      // Write then read back the same address on consecutive cycles.
      req_valid = '0;
      set_req(0, 1'b1, 3, 4'hA);
      step();
      set_req(0, 1'b0, 3, 0);
      step();
      req_valid = '0;
      step();
      check_value("wr_rd_valid", obs_rsp_v, 3'b001);
      check_value("wr_rd_data", obs_rsp_d[0], 4'hA);

      // Write-write collision on address 5.
      set_ptr(0);
      set_req(0, 1'b1, 5, 4'h3);
      set_req(1, 1'b1, 5, 4'hC);
      step();
      check_value("ww_first", obs_ready, 3'b001);
      req_valid[0] = 1'b0;
      step();
      check_value("ww_second", obs_ready, 3'b010);
      req_valid = '0;
      set_req(2, 1'b0, 5, 0);
      step();
      req_valid = '0;
      step();
      check_value("ww_final", obs_rsp_d[2], 4'hC);

      // Read-write collision on address 7, then read-read on the same address.
      set_req(0, 1'b1, 7, 4'h6);
      step();
      set_ptr(1);
      set_req(1, 1'b0, 7, 0);
      set_req(2, 1'b1, 7, 4'h9);
      step();
      check_value("rw_first", obs_ready, 3'b010);
      req_valid[1] = 1'b0;
      step();
      check_value("rw_second", obs_ready, 3'b100);
      check_value("rw_old_data", obs_rsp_d[1], 4'h6);
      req_valid = '0;
      set_req(1, 1'b0, 7, 0);
      set_req(2, 1'b0, 7, 0);
      step();
      check_value("rr_same_addr", obs_ready, 3'b110);
      req_valid = '0;
      step();
      check_value("rr_same_valid", obs_rsp_v, 3'b110);
      check_value("rr_same_data1", obs_rsp_d[1], 4'h9);
      check_value("rr_same_data2", obs_rsp_d[2], 4'h9);

      // Reset lands on a read that is in flight.
      set_req(0, 1'b0, 3, 0);
      step();
      req_valid = '1;
      do_reset();
      req_valid = '0;
      repeat (3) begin
         step();
         check_value("no_late_rsp", obs_rsp_v, 0);
      end

      // Random traffic: requests hold until granted.
      repeat (400) begin
         for (int i = 0; i < N; i++)
            if (!req_valid[i] && $urandom_range(0, 9) < 6)
               set_req(i, 1'(($urandom_range(0, 1))), int'($urandom_range(0, 15)),
                       int'($urandom_range(0, 15)));
         step();
         for (int i = 0; i < N; i++)
            if (m_gnt[i]) req_valid[i] = 1'b0;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
